// File: rtl/hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared definitions for the pipeline hazard controller:
//   - forwarding-mux select encodings for the D/E operand muxes (3 bit)
//     and the M-stage store-data mux (2 bit)
//   - tuse / tnew timing constants
//   - multiply/divide start opcodes seen in E
//   - shadow pipeline entry struct and its per-stage ageing helper
// ---------------------------------------------------------------------------
package hazard_ctrl_pkg;

   // D/E operand forwarding selects
   localparam logic [2:0] FW_RF     = 3'd0;  // register file / pipeline value
   localparam logic [2:0] FW_AO_M   = 3'd1;  // ALU/memory result held in M
   localparam logic [2:0] FW_PC8_M  = 3'd2;  // link address held in M
   localparam logic [2:0] FW_MWD    = 3'd3;  // write-back data in W
   localparam logic [2:0] FW_PC8_W  = 3'd4;  // link address in W

   // M-stage store-data (rt_M) forwarding selects
   localparam logic [1:0] FWM_RT    = 2'd0;
   localparam logic [1:0] FWM_MWD   = 2'd1;
   localparam logic [1:0] FWM_PC8_W = 2'd2;

   // Cycles until the D instruction consumes an operand
   typedef enum logic [1:0] {
      TUSE_D    = 2'd0,
      TUSE_E    = 2'd1,
      TUSE_M    = 2'd2,
      TUSE_NONE = 2'd3
   } tuse_e;

   // Cycles (from E entry) until a result is forwardable.
   // ALU ops and jal/jalr use TNEW_ONE, loads use TNEW_TWO.
   typedef enum logic [1:0] {
      TNEW_READY = 2'd0,
      TNEW_ONE   = 2'd1,
      TNEW_TWO   = 2'd2
   } tnew_e;

   // Multiply/divide start request from the E stage
   typedef enum logic [1:0] {
      MD_NONE = 2'd0,
      MD_MULT = 2'd1,
      MD_DIV  = 2'd2
   } md_op_e;

   // One shadow pipeline entry; an all-zero entry is a bubble (dst 0 = no write)
   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] dst;
      logic [1:0] tnew;
      logic       src;   // 0 = ALU/MEM data, 1 = PC8 link value
   } shadow_t;

   // Advance an entry by one stage: tnew counts down and saturates at 0
   function automatic shadow_t age(input shadow_t e);
      shadow_t a;
      a = e;
      if (e.tnew != 2'd0) begin
         a.tnew = e.tnew - 2'd1;
      end
      return a;
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
// Bundle between the core datapath and the hazard controller.
//   master : datapath side, drives D-stage decode info and md_start_e,
//            receives stall/bubble and forwarding selects
//   slave  : hazard controller side
// Contract: stall and clr_e are combinational in the same cycle as the
// D-stage info. While stall is high the datapath holds PC and F/D and loads
// a bubble into D/E; the D instruction is presented again the next cycle.
// The controller tracks an instruction only once it has been accepted into E.
// ---------------------------------------------------------------------------
interface hazard_ctrl_if;

   logic [4:0] rs_d;
   logic [4:0] rt_d;
   logic [1:0] tuse_rs_d;
   logic [1:0] tuse_rt_d;
   logic [4:0] dst_d;
   logic [1:0] tnew_d;
   logic       src_d;
   logic       md_use_d;
   logic [1:0] md_start_e;

   logic       stall;
   logic       clr_e;
   logic [2:0] forwardRSD;
   logic [2:0] forwardRTD;
   logic [2:0] forwardRSE;
   logic [2:0] forwardRTE;
   logic [1:0] forwardRTM;

   modport master (
      output rs_d, rt_d, tuse_rs_d, tuse_rt_d, dst_d, tnew_d, src_d,
             md_use_d, md_start_e,
      input  stall, clr_e, forwardRSD, forwardRTD, forwardRSE, forwardRTE,
             forwardRTM
   );

   modport slave (
      input  rs_d, rt_d, tuse_rs_d, tuse_rt_d, dst_d, tnew_d, src_d,
             md_use_d, md_start_e,
      output stall, clr_e, forwardRSD, forwardRTD, forwardRSE, forwardRTE,
             forwardRTM
   );

endinterface

// File: rtl/hazard_fwd_sel.sv
// ---------------------------------------------------------------------------
// hazard_fwd_sel
// Combinational forwarding matcher for one source operand.
//   r              : operand register number
//   m_dst/m_tnew/m_src : destination, remaining tnew and source of the M entry
//   w_dst/w_src    : destination and source of the W entry
//   code           : forward select
// RTM_MODE = 0: D/E operand mux. M (only once its tnew has reached 0) beats W.
// RTM_MODE = 1: M-stage store-data mux; only W is considered and the result
//               uses the 2-bit FWM_* encodings, zero-extended.
// Register 0 never matches.
// ---------------------------------------------------------------------------
module hazard_fwd_sel
   import hazard_ctrl_pkg::*;
#(
   parameter bit RTM_MODE = 1'b0
) (
   input  logic [4:0] r,
   input  logic [4:0] m_dst,
   input  logic [1:0] m_tnew,
   input  logic       m_src,
   input  logic [4:0] w_dst,
   input  logic       w_src,
   output logic [2:0] code
);

   logic m_hit;
   logic w_hit;

   always_comb begin
      m_hit = (r != 5'd0) && (r == m_dst) && (m_tnew == 2'd0);
      w_hit = (r != 5'd0) && (r == w_dst);
      code  = RTM_MODE ? {1'b0, FWM_RT} : FW_RF;
      if (RTM_MODE) begin
         if (w_hit) begin
            code = {1'b0, (w_src ? FWM_PC8_W : FWM_MWD)};
         end
      end else if (m_hit) begin
         code = m_src ? FW_PC8_M : FW_AO_M;
      end else if (w_hit) begin
         code = w_src ? FW_PC8_W : FW_MWD;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller for the five-stage core. Keeps a shadow copy of
// {rs, rt, dst, tnew, src} for the E, M and W stages plus a mult/div busy
// counter, and from those and the D-stage info produces the stall/bubble
// controls and forwarding-mux selects.
// Ports:
//   clk          core clock
//   reset        synchronous, active-low; clears shadow entries and busy count
//   bus          hazard_ctrl_if.slave (D-stage info in, stall/forward out)
//   busy_cnt_dbg current mult/div busy count, for observation
// Parameters:
//   MULT_CYC     E-stage cycles occupied by mult/multu
//   DIV_CYC      E-stage cycles occupied by div/divu
// ---------------------------------------------------------------------------
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10
) (
   input  logic                           clk,
   input  logic                           reset,
   hazard_ctrl_if.slave                   bus,
   output logic [$clog2(DIV_CYC+1)-1:0]   busy_cnt_dbg
);

   localparam int BUSY_W = $clog2(DIV_CYC + 1);
   localparam logic [BUSY_W-1:0] MULT_LOAD = BUSY_W'(MULT_CYC);
   localparam logic [BUSY_W-1:0] DIV_LOAD  = BUSY_W'(DIV_CYC);

   shadow_t           e_q, m_q, w_q;
   shadow_t           d_ent;
   logic [BUSY_W-1:0] busy_q;
   logic              data_stall;
   logic              md_stall;
   logic              stall;
   logic [2:0]        rtm_code;
   logic              unused_bits;

   // A D operand read in tuse cycles must wait while a producer in E or M
   // still needs more than tuse cycles before its result is forwardable.
   function automatic logic data_hazard(input logic [4:0] r,
                                        input logic [1:0] tuse,
                                        input shadow_t    e,
                                        input shadow_t    m);
      logic hit_e;
      logic hit_m;
      hit_e = (r == e.dst) && (e.tnew > tuse);
      hit_m = (r == m.dst) && (m.tnew > tuse);
      return (tuse != TUSE_NONE) && (r != 5'd0) && (hit_e || hit_m);
   endfunction

   always_comb begin
      d_ent      = '0;
      d_ent.rs   = bus.rs_d;
      d_ent.rt   = bus.rt_d;
      d_ent.dst  = bus.dst_d;
      d_ent.tnew = bus.tnew_d;
      d_ent.src  = bus.src_d;

      data_stall = data_hazard(bus.rs_d, bus.tuse_rs_d, e_q, m_q) ||
                   data_hazard(bus.rt_d, bus.tuse_rt_d, e_q, m_q);
      // A start in E this cycle counts as busy: the counter loads on this edge.
      md_stall   = bus.md_use_d &&
                   ((busy_q != '0) || (bus.md_start_e != MD_NONE));
      stall      = data_stall || md_stall;
   end

   assign bus.stall    = stall;
   assign bus.clr_e    = stall;
   assign busy_cnt_dbg = busy_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         e_q    <= '0;
         m_q    <= '0;
         w_q    <= '0;
         busy_q <= '0;
      end else begin
         w_q <= age(m_q);
         m_q <= age(e_q);
         e_q <= stall ? shadow_t'('0) : d_ent;
         if (bus.md_start_e == MD_MULT) begin
            busy_q <= MULT_LOAD;
         end else if (bus.md_start_e != MD_NONE) begin
            busy_q <= DIV_LOAD;
         end else if (busy_q != '0) begin
            busy_q <= busy_q - 1'b1;
         end
      end
   end

   hazard_fwd_sel #(.RTM_MODE(1'b0)) u_fwd_rsd (
      .r(bus.rs_d), .m_dst(m_q.dst), .m_tnew(m_q.tnew), .m_src(m_q.src),
      .w_dst(w_q.dst), .w_src(w_q.src), .code(bus.forwardRSD)
   );

   hazard_fwd_sel #(.RTM_MODE(1'b0)) u_fwd_rtd (
      .r(bus.rt_d), .m_dst(m_q.dst), .m_tnew(m_q.tnew), .m_src(m_q.src),
      .w_dst(w_q.dst), .w_src(w_q.src), .code(bus.forwardRTD)
   );

   hazard_fwd_sel #(.RTM_MODE(1'b0)) u_fwd_rse (
      .r(e_q.rs), .m_dst(m_q.dst), .m_tnew(m_q.tnew), .m_src(m_q.src),
      .w_dst(w_q.dst), .w_src(w_q.src), .code(bus.forwardRSE)
   );

   hazard_fwd_sel #(.RTM_MODE(1'b0)) u_fwd_rte (
      .r(e_q.rt), .m_dst(m_q.dst), .m_tnew(m_q.tnew), .m_src(m_q.src),
      .w_dst(w_q.dst), .w_src(w_q.src), .code(bus.forwardRTE)
   );

   // Store data in M can only come from W; the M inputs are tied off.
   hazard_fwd_sel #(.RTM_MODE(1'b1)) u_fwd_rtm (
      .r(m_q.rt), .m_dst(5'd0), .m_tnew(2'd0), .m_src(1'b0),
      .w_dst(w_q.dst), .w_src(w_q.src), .code(rtm_code)
   );

   assign bus.forwardRTM = rtm_code[1:0];

   // Fields carried along for completeness but not needed by any decision.
   assign unused_bits = ^{m_q.rs, w_q.rs, w_q.rt, w_q.tnew, rtm_code[2]};

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Table of per-cycle D-stage inputs with hand-derived expected outputs,
// followed by loop-built mult/div stall sequences.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

   localparam int MULT_CYC = 5;
   localparam int DIV_CYC  = 10;
   localparam int BW       = $clog2(DIV_CYC + 1);
   localparam int W        = 16 + BW;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   logic [BW-1:0] busy_cnt_dbg;

   always #5 clk = ~clk;

   hazard_ctrl_if bus();

   hazard_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus),
      .busy_cnt_dbg(busy_cnt_dbg)
   );

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;
   logic [W-1:0] exp_q[$];
   string        name_q[$];

   typedef struct {
      string        name;
      bit           rst;
      logic [4:0]   rs;
      logic [4:0]   rt;
      logic [1:0]   tur;
      logic [1:0]   tut;
      logic [4:0]   dst;
      logic [1:0]   tnew;
      logic         src;
      logic         mdu;
      logic [1:0]   mds;
      logic [W-1:0] exp;
   } vec_t;

   vec_t vecs[$];

   // {stall, clr_e, RSD, RTD, RSE, RTE, RTM, busy}; clr_e always equals stall
   function automatic logic [W-1:0] ex(input bit st, input int rsd, input int rtd,
                                       input int rse, input int rte, input int rtm,
                                       input int busy);
      return {st, st, 3'(rsd), 3'(rtd), 3'(rse), 3'(rte), 2'(rtm), BW'(busy)};
   endfunction

   function automatic vec_t row(input string n, input bit rst,
                                input int rs, input int rt, input int tur, input int tut,
                                input int dst, input int tnew, input int src,
                                input int mdu, input int mds, input logic [W-1:0] e);
      vec_t v;
      v.name = n;
      v.rst  = rst;
      v.rs   = 5'(rs);
      v.rt   = 5'(rt);
      v.tur  = 2'(tur);
      v.tut  = 2'(tut);
      v.dst  = 5'(dst);
      v.tnew = 2'(tnew);
      v.src  = 1'(src);
      v.mdu  = 1'(mdu);
      v.mds  = 2'(mds);
      v.exp  = e;
      return v;
   endfunction

   function automatic vec_t rst_row();
      return row("rst", 1'b1, 0, 0, 3, 3, 0, 0, 0, 0, 0, '0);
   endfunction

   function automatic vec_t nop(input string n, input logic [W-1:0] e);
      return row(n, 1'b0, 0, 0, 3, 3, 0, 0, 0, 0, 0, e);
   endfunction

   function automatic logic [W-1:0] get_out();
      return {bus.stall, bus.clr_e, bus.forwardRSD, bus.forwardRTD,
              bus.forwardRSE, bus.forwardRTE, bus.forwardRTM, busy_cnt_dbg};
   endfunction

   function automatic string fmt(input logic [W-1:0] v);
      return $sformatf("stall=%0b clr=%0b rsd=%0d rtd=%0d rse=%0d rte=%0d rtm=%0d busy=%0d",
                       v[W-1], v[W-2], v[W-3 -: 3], v[W-6 -: 3], v[W-9 -: 3],
                       v[W-12 -: 3], v[W-15 -: 2], v[BW-1:0]);
   endfunction

   task automatic check();
      logic [W-1:0] e;
      logic [W-1:0] g;
      string        n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      g = get_out();
      total++;
      if (g !== e) begin
         bad++;
         $display("FAIL %s: got {%s} expected {%s}", n, fmt(g), fmt(e));
      end
   endtask

   // ---------------- driver ----------------
   // Called just after a rising edge; drives one cycle and samples at negedge.
   task automatic apply(input vec_t v);
      reset          = v.rst ? 1'b0 : 1'b1;
      bus.rs_d       = v.rs;
      bus.rt_d       = v.rt;
      bus.tuse_rs_d  = v.tur;
      bus.tuse_rt_d  = v.tut;
      bus.dst_d      = v.dst;
      bus.tnew_d     = v.tnew;
      bus.src_d      = v.src;
      bus.md_use_d   = v.mdu;
      bus.md_start_e = v.mds;
      if (!v.rst) begin
         exp_q.push_back(v.exp);
         name_q.push_back(v.name);
      end
      @(negedge clk);
      if (!v.rst) check();
      @(posedge clk);
      #1;
   endtask

   // mflo held in D while a mult/div starts in E: stalls for cyc+1 cycles,
   // busy counts cyc..1 after the start edge.
   task automatic md_run(input string n, input int start, input int cyc);
      int dst;
      dst = $urandom_range(1, 31);
      apply(rst_row());
      for (int i = 0; i <= cyc + 1; i++) begin
         apply(row($sformatf("%s_c%0d", n, i), 1'b0, 0, 0, 3, 3, dst, 1, 0, 1,
                   (i == 0) ? start : 0,
                   ex(i <= cyc, 0, 0, 0, 0, 0, (i == 0) ? 0 : cyc - i + 1)));
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset          = 1'b0;
      bus.rs_d       = '0;
      bus.rt_d       = '0;
      bus.tuse_rs_d  = 2'd3;
      bus.tuse_rt_d  = 2'd3;
      bus.dst_d      = '0;
      bus.tnew_d     = '0;
      bus.src_d      = 1'b0;
      bus.md_use_d   = 1'b0;
      bus.md_start_e = '0;
      repeat (2) @(posedge clk);
      #1;

      // reset state
      vecs.push_back(rst_row());
      vecs.push_back(nop("reset_state", ex(0, 0, 0, 0, 0, 0, 0)));
      // add $1 chain
      vecs.push_back(row("add1",          0, 2, 3, 1, 1, 1, 1, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0)));
      vecs.push_back(row("add2_no_stall", 0, 1, 5, 1, 1, 4, 1, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0)));
      vecs.push_back(row("add3_fwd_ao_m", 0, 1, 0, 1, 1, 6, 1, 0, 0, 0, ex(0, 1, 0, 1, 0, 0, 0)));
      vecs.push_back(row("add4_fwd_mwd",  0, 1, 4, 1, 1, 7, 1, 0, 0, 0, ex(0, 3, 1, 3, 0, 0, 0)));
      vecs.push_back(nop("add_tail_rte",  ex(0, 0, 0, 0, 3, 0, 0)));
      // lw $2 ; beq $2 (tuse 0)
      vecs.push_back(rst_row());
      vecs.push_back(row("lw2",           0, 5, 0, 1, 3, 2, 2, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0)));
      vecs.push_back(row("beq_stall1",    0, 2, 6, 0, 0, 0, 0, 0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0)));
      vecs.push_back(row("beq_stall2",    0, 2, 6, 0, 0, 0, 0, 0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0)));
      vecs.push_back(row("beq_release",   0, 2, 6, 0, 0, 0, 0, 0, 0, 0, ex(0, 3, 0, 0, 0, 0, 0)));
      vecs.push_back(nop("beq_tail",      ex(0, 0, 0, 0, 0, 0, 0)));
      // jal ; jr $31 ; second reader
      vecs.push_back(rst_row());
      vecs.push_back(row("jal",           0, 0, 0, 3, 3, 31, 1, 1, 0, 0, ex(0, 0, 0, 0, 0, 0, 0)));
      vecs.push_back(row("jr_stall",      0, 31, 0, 0, 3, 0, 0, 0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0)));
      vecs.push_back(row("jr_fwd_pc8_m",  0, 31, 0, 0, 3, 0, 0, 0, 0, 0, ex(0, 2, 0, 0, 0, 0, 0)));
      vecs.push_back(row("rd_fwd_pc8_w",  0, 31, 31, 1, 1, 8, 1, 0, 0, 0, ex(0, 4, 4, 4, 0, 0, 0)));
      vecs.push_back(nop("jal_tail",      ex(0, 0, 0, 0, 0, 0, 0)));
      // lw $3 ; sw $3 (rt tuse 2)
      vecs.push_back(rst_row());
      vecs.push_back(row("lw3",           0, 4, 0, 1, 3, 3, 2, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0)));
      vecs.push_back(row("sw_no_stall",   0, 5, 3, 1, 2, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0)));
      vecs.push_back(nop("sw_in_e",       ex(0, 0, 0, 0, 0, 0, 0)));
      vecs.push_back(nop("sw_fwd_rtm",    ex(0, 0, 0, 0, 0, 1, 0)));
      // write $0 ; read $0
      vecs.push_back(rst_row());
      vecs.push_back(row("write_r0",      0, 1, 0, 1, 3, 0, 1, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0)));
      vecs.push_back(row("read_r0_a",     0, 0, 0, 0, 0, 9, 1, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0)));
      vecs.push_back(row("read_r0_b",     0, 0, 0, 0, 0, 9, 1, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0)));
      // mult started without a HI/LO user, then mflo while busy
      vecs.push_back(rst_row());
      vecs.push_back(row("mult_no_use",   0, 0, 0, 3, 3, 0, 0, 0, 0, 1, ex(0, 0, 0, 0, 0, 0, 0)));
      vecs.push_back(nop("mult_busy",     ex(0, 0, 0, 0, 0, 0, MULT_CYC)));
      vecs.push_back(row("mflo_busy4",    0, 0, 0, 3, 3, 12, 1, 0, 1, 0, ex(1, 0, 0, 0, 0, 0, MULT_CYC - 1)));
      vecs.push_back(row("mflo_busy3",    0, 0, 0, 3, 3, 12, 1, 0, 1, 0, ex(1, 0, 0, 0, 0, 0, MULT_CYC - 2)));
      // div with mflo in D, reset asserted in the fifth cycle
      vecs.push_back(rst_row());
      vecs.push_back(row("div_start",     0, 0, 0, 3, 3, 10, 1, 0, 1, 2, ex(1, 0, 0, 0, 0, 0, 0)));
      vecs.push_back(row("div_busy_a",    0, 0, 0, 3, 3, 10, 1, 0, 1, 0, ex(1, 0, 0, 0, 0, 0, DIV_CYC)));
      vecs.push_back(row("div_busy_b",    0, 0, 0, 3, 3, 10, 1, 0, 1, 0, ex(1, 0, 0, 0, 0, 0, DIV_CYC - 1)));
      vecs.push_back(row("div_busy_c",    0, 0, 0, 3, 3, 10, 1, 0, 1, 0, ex(1, 0, 0, 0, 0, 0, DIV_CYC - 2)));
      vecs.push_back(row("div_rst",       1, 0, 0, 3, 3, 10, 1, 0, 1, 0, '0));
      vecs.push_back(row("div_after_rst", 0, 0, 0, 3, 3, 10, 1, 0, 1, 0, ex(0, 0, 0, 0, 0, 0, 0)));

      foreach (vecs[i]) apply(vecs[i]);

      // full-length multi-cycle stalls
      md_run("div_mflo",  2, DIV_CYC);
      md_run("mult_mflo", 1, MULT_CYC);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage core. Keeps a shadow pipeline of destination-register and result-timing info for the E, M and W stages, plus a multiply/divide busy counter. Each cycle it drives the select codes of the forwarding multiplexer and the stall/bubble signals for the F/D and D/E pipeline registers.

## Interface
Parameters:
- MULT_CYC, 5: E-stage cycles occupied by mult/multu.
- DIV_CYC, 10: E-stage cycles occupied by div/divu.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-low; clears all state on the rising edge of clk while low.
- rs_d, rt_d  in  5  source register numbers of the D-stage instruction.
- tuse_rs_d, tuse_rt_d  in  2  cycles until the D instruction consumes rs/rt: 0 = D, 1 = E, 2 = M; 3 = operand unused.
- dst_d  in  5  destination register of the D instruction; 0 = no write.
- tnew_d  in  2  cycles, counted from E entry, until the result is forwardable: ALU 1, load 2, jal/jalr 1.
- src_d  in  1  result source: 0 = ALU/MEM data, 1 = PC8 (link).
- md_use_d  in  1  D instruction touches HI/LO (mult/div/mfhi/mflo/mthi/mtlo).
- md_start_e  in  2  E instruction starts the multiply/divide unit: 0 none, 1 mult, 2 div.
- stall  out  1  freeze PC and F/D register.
- clr_e  out  1  load a bubble into the D/E register.
- forwardRSD, forwardRTD, forwardRSE, forwardRTE  out  3  selects: 0 register/pipeline value, 1 AO_M, 2 PC8_M, 3 MWD, 4 PC8_W.
- forwardRTM  out  2  selects: 0 RT_M, 1 MWD, 2 PC8_W.

## Operation
- Shadow entries E, M, W each hold {rs, rt, dst, tnew, src}. On reset all fields are 0, so dst = 0 means no hazard.
- Every cycle the entries shift: W←M, M←E. On shift, tnew saturating-decrements to 0.
- E←D when stall = 0. When stall = 1, the E entry is loaded with a bubble (all zero).
- Only instructions reaching E are tracked. E is the only cycle an instruction can stall in D.
- Match X(r) holds when r ≠ 0 and r == dst_X.
- Data stall, for each operand with tuse t < 3:
  - Match E and tnew_E > t, or
  - Match M and tnew_M > t.
- MD stall: md_use_d and (busy_cnt ≠ 0 or md_start_e ≠ 0).
- stall = data stall OR MD stall. clr_e = stall.
- D forward, for each of rs_d and rt_d:
  - Match M and tnew_M == 0 → 1 if src_M = 0, else 2.
  - Else match W → 3 if src_W = 0, else 4.
  - Else 0.
  - M has priority over W.
- E forward: same rule using rs_E and rt_E.
- M forward (rt_M): match W → 1 if src_W = 0, else 2; otherwise 0.
- Forward codes are produced regardless of stall. They are don't-care while stalling but must stay in the legal encodings. Codes 5–7 and 3 on the 2-bit select are never driven.
- busy_cnt:
  - Loads MULT_CYC or DIV_CYC on md_start_e ≠ 0.
  - Otherwise decrements while nonzero.
  - Width is clog2(DIV_CYC+1).
  - Reset → 0.

## Timing
- Outputs are combinational from the D inputs and registered state. There is no added latency.
- Shadow registers and busy_cnt update on the rising edge of clk.
- Reset values: all entries zero, busy_cnt 0. Therefore stall = 0, clr_e = 0 and all forward codes 0 (unless D inputs alone force an MD stall, which cannot happen with busy 0 and E empty).
- Reset asserted mid-stall or mid-divide: the next edge clears everything; no stall is carried over.
- A load followed by a dependent instruction with tuse 0 stalls 2 cycles. With tuse 1 it stalls 1 cycle.
- md_start_e and md_use_d in the same cycle → stall. busy_cnt loads on the same edge.
- A multiply therefore stalls a dependent mflo for MULT_CYC+1 cycles after entering E.
- Register 0 never matches, even when dst = 0 appears in an entry.

## Structure
- Shared package: forward-select encodings (FW_RF, FW_AO_M, FW_PC8_M, FW_MWD, FW_PC8_W; FWM_RT, FWM_MWD, FWM_PC8_W), tuse/tnew constants, and the shadow-entry struct.
- One sub-module, hazard_fwd_sel: a combinational matcher that takes one operand plus the M and W entries and returns a code. It is instantiated for RSD, RTD, RSE and RTE. The RTM variant is a parameterised mode.

## Test plan
- Add $1 then dependent add $1 (tuse 1) → no stall. Next cycle forwardRSE = 1. One cycle later, a consumer in D sees forwardRSD = 3.
- lw $2 then beq $2 (tuse 0) → stall = clr_e = 1 for 2 cycles, then forwardRSD = 3.
- jal (dst 31, src 1) then jr $31 → 1 stall, then forwardRSD = 2. One cycle later a second reader gets 4.
- lw $3 then sw $3 (rt tuse 2) → no stall. forwardRTM = 1 when the sw is in M.
- div in E, mflo in D → stall for 11 cycles (busy 10 plus the start cycle). Assert reset low on cycle 4 → busy_cnt and stall are 0 on the next cycle.
- Write to $0 then read $0 → all forward codes 0, no stall.
